// File: rtl/mem_arbiter_6502_pkg.sv
// rtl/mem_arbiter_6502_pkg.sv - shared types and widths for the 6502 memory arbiter
package mem_arb_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;

    typedef enum logic {OWN_CPU, OWN_HOST} owner_e;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } host_req_t;

endpackage

// File: rtl/mem_arbiter_6502_if.sv
// rtl/mem_arbiter_6502_if.sv - CPU, host and RAM signal bundle around the arbiter
interface mem_arbiter_6502_if;
    import mem_arb_pkg::*;

    logic [ADDR_W-1:0] cpu_ab;
    logic [DATA_W-1:0] cpu_do;
    logic              cpu_we;
    logic [DATA_W-1:0] cpu_di;
    logic              cpu_rdy;

    logic              host_req;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_gnt;
    logic              host_rvalid;
    logic [DATA_W-1:0] host_rdata;

    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  cpu_ab, cpu_do, cpu_we, host_req, host_we, host_addr, host_wdata, ram_rdata,
        output cpu_di, cpu_rdy, host_gnt, host_rvalid, host_rdata, ram_addr, ram_we, ram_wdata
    );

    modport master (
        output cpu_ab, cpu_do, cpu_we, host_req, host_we, host_addr, host_wdata, ram_rdata,
        input  cpu_di, cpu_rdy, host_gnt, host_rvalid, host_rdata, ram_addr, ram_we, ram_wdata
    );

endinterface

// File: rtl/mem_arbiter_6502_sat_counter.sv
// rtl/mem_arbiter_6502_sat_counter.sv - saturating up-counter with enable and synchronous clear
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter_6502.sv
// rtl/mem_arbiter_6502.sv - shares one synchronous RAM between the 6502 core and a host port
module mem_arbiter_6502
    import mem_arb_pkg::*;
#(
    parameter int HOST_BURST = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    mem_arbiter_6502_if.slave        bus,
    output logic [31:0]              stall_cycles
);

    localparam logic [3:0] BURST_MAX = 4'(HOST_BURST);

    owner_e            owner_q;
    logic [3:0]        burst_cnt;
    logic [DATA_W-1:0] di_hold;
    logic              host_gnt;
    host_req_t         host;

    assign host = '{we: bus.host_we, addr: bus.host_addr, wdata: bus.host_wdata};

    // Host steals the cycle only while its burst allowance lasts; reset always leaves the port to the CPU.
    assign host_gnt     = bus.host_req && !rst && (burst_cnt < BURST_MAX);
    assign bus.host_gnt = host_gnt;
    assign bus.cpu_rdy  = !host_gnt;

    assign bus.ram_addr  = host_gnt ? host.addr  : bus.cpu_ab;
    assign bus.ram_we    = host_gnt ? host.we    : bus.cpu_we;
    assign bus.ram_wdata = host_gnt ? host.wdata : bus.cpu_do;

    // DI is frozen while the previous cycle belonged to the host, mimicking an RDY-gated output register.
    assign bus.cpu_di     = (owner_q == OWN_CPU) ? bus.ram_rdata : di_hold;
    assign bus.host_rdata = bus.ram_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q         <= OWN_CPU;
            burst_cnt       <= 4'd0;
            di_hold         <= '0;
            bus.host_rvalid <= 1'b0;
        end else begin
            owner_q         <= host_gnt ? OWN_HOST : OWN_CPU;
            burst_cnt       <= host_gnt ? burst_cnt + 4'd1 : 4'd0;
            di_hold         <= bus.cpu_di;
            bus.host_rvalid <= host_gnt && !bus.host_we;
        end
    end

    sat_counter #(.W(32)) u_stall_cnt (
        .clk   (clk),
        .clr   (rst),
        .en    (host_gnt),
        .count (stall_cycles)
    );

endmodule

// File: tb/tb_mem_arbiter_6502.sv
// tb/tb_mem_arbiter_6502.sv - directed vector bench for mem_arbiter_6502 with a 1-cycle RAM model
module tb_mem_arbiter_6502;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] stall_cycles;
    logic [7:0]  mem [0:65535];
    logic [7:0]  ram_q;
    int          n_pass = 0;
    int          n_total = 0;

    always #5 clk = ~clk;

    mem_arbiter_6502_if bus ();

    mem_arbiter_6502 #(.HOST_BURST(3)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus.slave),
        .stall_cycles (stall_cycles)
    );

    // Synchronous RAM: registered read, old data on read-during-write.
    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
        ram_q <= mem[bus.ram_addr];
    end
    assign bus.ram_rdata = ram_q;

    typedef struct {
        logic        h_req;
        logic        h_we;
        logic [15:0] h_addr;
        logic [7:0]  h_wdata;
        logic [15:0] c_ab;
        logic        c_we;
        logic [7:0]  c_do;
        logic        e_gnt;
        logic [15:0] e_ram_addr;
        logic        e_ram_we;
        logic [7:0]  e_ram_wdata;
        logic        e_rvalid;
        logic [7:0]  e_rdata;
        logic [31:0] e_stall;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input logic h_req, input logic h_we, input logic [15:0] h_addr,
                         input logic [7:0] h_wdata, input logic [15:0] c_ab,
                         input logic c_we, input logic [7:0] c_do);
        bus.host_req   = h_req;
        bus.host_we    = h_we;
        bus.host_addr  = h_addr;
        bus.host_wdata = h_wdata;
        bus.cpu_ab     = c_ab;
        bus.cpu_we     = c_we;
        bus.cpu_do     = c_do;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
        mem[16'h0400] = 8'h40;
        mem[16'h0401] = 8'h41;
        mem[16'h0402] = 8'h42;

        //            req we  haddr    hwd    cab      cwe  cdo   | gnt raddr   rwe rwd    rv  rdata  stall
        vecs[0] = '{1'b0, 1'b0, 16'h0000, 8'h00, 16'h1234, 1'b0, 8'h00, 1'b0, 16'h1234, 1'b0, 8'h00, 1'b0, 8'h00, 32'd0};
        vecs[1] = '{1'b0, 1'b0, 16'h0000, 8'h00, 16'h0010, 1'b1, 8'h11, 1'b0, 16'h0010, 1'b1, 8'h11, 1'b0, 8'h00, 32'd0};
        vecs[2] = '{1'b1, 1'b1, 16'h0300, 8'hA5, 16'h2000, 1'b0, 8'h00, 1'b1, 16'h0300, 1'b1, 8'hA5, 1'b0, 8'h00, 32'd0};
        vecs[3] = '{1'b1, 1'b0, 16'h0400, 8'h00, 16'h0020, 1'b1, 8'h22, 1'b1, 16'h0400, 1'b0, 8'h00, 1'b0, 8'h00, 32'd1};
        vecs[4] = '{1'b1, 1'b0, 16'h0401, 8'h00, 16'h0020, 1'b1, 8'h22, 1'b1, 16'h0401, 1'b0, 8'h00, 1'b1, 8'h40, 32'd2};
        vecs[5] = '{1'b1, 1'b0, 16'h0402, 8'h00, 16'h0020, 1'b1, 8'h22, 1'b0, 16'h0020, 1'b1, 8'h22, 1'b1, 8'h41, 32'd3};
        vecs[6] = '{1'b1, 1'b0, 16'h0402, 8'h00, 16'h0040, 1'b0, 8'h00, 1'b1, 16'h0402, 1'b0, 8'h00, 1'b0, 8'h00, 32'd3};
        vecs[7] = '{1'b0, 1'b0, 16'h0000, 8'h00, 16'h0030, 1'b1, 8'h33, 1'b0, 16'h0030, 1'b1, 8'h33, 1'b1, 8'h42, 32'd4};

        // Reset with the host requesting: CPU must keep the port.
        rst = 1'b1;
        drive(1'b1, 1'b0, 16'h0400, 8'h00, 16'hFFFC, 1'b0, 8'h00);
        repeat (3) step();
        @(negedge clk);
        check("rst_gnt", 32'(bus.host_gnt), 32'd0);
        check("rst_rdy", 32'(bus.cpu_rdy), 32'd1);
        step();
        rst = 1'b0;
        drive(1'b0, 1'b0, 16'h0000, 8'h00, 16'hFFFC, 1'b0, 8'h00);
        @(negedge clk);
        check("reset_rvalid", 32'(bus.host_rvalid), 32'd0);
        check("reset_stall", stall_cycles, 32'd0);
        step();

        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].h_req, vecs[i].h_we, vecs[i].h_addr, vecs[i].h_wdata,
                  vecs[i].c_ab, vecs[i].c_we, vecs[i].c_do);
            @(negedge clk);
            check($sformatf("v%0d_gnt", i), 32'(bus.host_gnt), 32'(vecs[i].e_gnt));
            check($sformatf("v%0d_rdy", i), 32'(bus.cpu_rdy), 32'(!vecs[i].e_gnt));
            check($sformatf("v%0d_ram_addr", i), 32'(bus.ram_addr), 32'(vecs[i].e_ram_addr));
            check($sformatf("v%0d_ram_we", i), 32'(bus.ram_we), 32'(vecs[i].e_ram_we));
            check($sformatf("v%0d_ram_wdata", i), 32'(bus.ram_wdata), 32'(vecs[i].e_ram_wdata));
            check($sformatf("v%0d_rvalid", i), 32'(bus.host_rvalid), 32'(vecs[i].e_rvalid));
            if (vecs[i].e_rvalid)
                check($sformatf("v%0d_rdata", i), 32'(bus.host_rdata), 32'(vecs[i].e_rdata));
            check($sformatf("v%0d_stall", i), stall_cycles, vecs[i].e_stall);
            step();
        end

        // CPU LDA $0300 sees the host's earlier write.
        drive(1'b0, 1'b0, 16'h0000, 8'h00, 16'h0300, 1'b0, 8'h00);
        step();
        @(negedge clk);
        check("lda_0300", 32'(bus.cpu_di), 32'h0000_00A5);

        // Host read of 0xFFFC under CPU load: DI held through the stall.
        drive(1'b0, 1'b0, 16'h0000, 8'h00, 16'h0010, 1'b0, 8'h00);
        step();
        drive(1'b1, 1'b0, 16'hFFFC, 8'h00, 16'h0010, 1'b0, 8'h00);
        @(negedge clk);
        check("hrd_gnt", 32'(bus.host_gnt), 32'd1);
        check("hrd_di_before", 32'(bus.cpu_di), 32'h11);
        step();
        drive(1'b0, 1'b0, 16'h0000, 8'h00, 16'h0010, 1'b0, 8'h00);
        @(negedge clk);
        check("hrd_di_stall", 32'(bus.cpu_di), 32'h11);
        check("hrd_rvalid", 32'(bus.host_rvalid), 32'd1);
        check("hrd_rdata", 32'(bus.host_rdata), 32'h00);
        step();
        @(negedge clk);
        check("hrd_rvalid_drop", 32'(bus.host_rvalid), 32'd0);
        check("hrd_di_after", 32'(bus.cpu_di), 32'h11);
        step();

        // Burst fairness with HOST_BURST=3: grants 1,1,1,0 repeating.
        drive(1'b1, 1'b0, 16'h0500, 8'h00, 16'h0010, 1'b0, 8'h00);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check($sformatf("burst_gnt%0d", i), 32'(bus.host_gnt), 32'((i % 4) != 3));
            step();
        end
        drive(1'b0, 1'b0, 16'h0000, 8'h00, 16'h0010, 1'b0, 8'h00);
        @(negedge clk);
        check("burst_stall", stall_cycles, 32'd20);
        step();

        // Collision at 0x0200: host write first, CPU store replays next cycle.
        drive(1'b1, 1'b1, 16'h0200, 8'h77, 16'h0200, 1'b1, 8'h55);
        @(negedge clk);
        check("col_gnt", 32'(bus.host_gnt), 32'd1);
        check("col_host_wdata", 32'(bus.ram_wdata), 32'h77);
        step();
        drive(1'b0, 1'b0, 16'h0000, 8'h00, 16'h0200, 1'b1, 8'h55);
        @(negedge clk);
        check("col_cpu_we", 32'(bus.ram_we), 32'd1);
        check("col_cpu_wdata", 32'(bus.ram_wdata), 32'h55);
        step();
        drive(1'b0, 1'b0, 16'h0000, 8'h00, 16'h0200, 1'b0, 8'h00);
        step();
        @(negedge clk);
        check("col_final", 32'(bus.cpu_di), 32'h55);

        // Reset mid-burst after two grants.
        drive(1'b1, 1'b0, 16'h0600, 8'h00, 16'h0010, 1'b0, 8'h00);
        step();
        step();
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_gnt", 32'(bus.host_gnt), 32'd0);
        check("mid_rst_rdy", 32'(bus.cpu_rdy), 32'd1);
        step();
        @(negedge clk);
        check("mid_rst_rvalid", 32'(bus.host_rvalid), 32'd0);
        check("mid_rst_stall", stall_cycles, 32'd0);
        check("mid_rst_gnt2", 32'(bus.host_gnt), 32'd0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("post_rst_gnt%0d", i), 32'(bus.host_gnt), 32'(i != 3));
            step();
        end
        @(negedge clk);
        check("post_rst_stall", stall_cycles, 32'd3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
